// File: rtl/prefetch_pkg.sv
// Shared state encoding and default widths for the prefetch remaining-transfer counter.
package prefetch_pkg;

   localparam int CNT_W_DEF  = 23;
   localparam int STEP_W_DEF = 3;
   localparam int SEG_W_DEF  = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/remain_sub.sv
// Combinational remain - step subtractor: full subtract on the low STEP_W bits,
// then a half-subtract borrow chain in SEG_W segments with per-segment lookahead.
module remain_sub
   import prefetch_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int STEP_W = STEP_W_DEF,
   parameter int SEG_W  = SEG_W_DEF
) (
   input  logic [CNT_W-1:0]  i_a,
   input  logic [STEP_W-1:0] i_b,
   output logic [CNT_W-1:0]  o_diff,
   output logic              o_borrow
);

   localparam int UP_W = CNT_W - STEP_W;
   localparam int NSEG = (UP_W + SEG_W - 1) / SEG_W;

   logic [STEP_W:0] w_low;
   logic [NSEG:0]   w_seg_b;

   assign w_low               = {1'b0, i_a[STEP_W-1:0]} - {1'b0, i_b};
   assign o_diff[STEP_W-1:0]  = w_low[STEP_W-1:0];
   assign w_seg_b[0]          = w_low[STEP_W];
   assign o_borrow            = w_seg_b[NSEG];

   for (genvar s = 0; s < NSEG; s++) begin : g_seg
      localparam int LO  = STEP_W + s * SEG_W;
      localparam int HI  = (LO + SEG_W - 1 < CNT_W - 1) ? (LO + SEG_W - 1) : (CNT_W - 1);
      localparam int LEN = HI - LO + 1;

      logic [LEN-1:0] w_chain;

      assign w_chain[0] = w_seg_b[s];

      for (genvar k = 0; k < LEN; k++) begin : g_bit
         assign o_diff[LO+k] = i_a[LO+k] ^ w_chain[k];
         if (k < LEN - 1) begin : g_prop
            assign w_chain[k+1] = w_chain[k] & ~i_a[LO+k];
         end
      end

      // A borrow only leaves the segment when every bit in it is zero.
      assign w_seg_b[s+1] = w_seg_b[s] & ~(|i_a[HI:LO]);
   end

endmodule

// File: rtl/prefetch_remain_ctr.sv
// Remaining-transfer counter for the prefetch path: loaded with a length,
// decremented per accepted beat, flags last beat, completion and overrun.
module prefetch_remain_ctr
   import prefetch_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int STEP_W = STEP_W_DEF,
   parameter int SEG_W  = SEG_W_DEF
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              load,
   input  logic [CNT_W-1:0]  load_cnt,
   input  logic              abort,
   input  logic              step_valid,
   input  logic [STEP_W-1:0] step,
   output logic              step_ready,
   output logic [CNT_W-1:0]  remain,
   output logic              last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'((2 ** STEP_W) - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_remain;
   logic [CNT_W-1:0] w_remain_nxt;
   logic [CNT_W-1:0] w_diff;
   logic             w_borrow;
   logic             r_last;
   logic             w_last_nxt;
   logic             r_overrun;
   logic             w_overrun_nxt;

   remain_sub #(
      .CNT_W  (CNT_W),
      .STEP_W (STEP_W),
      .SEG_W  (SEG_W)
   ) u_remain_sub (
      .i_a      (r_remain),
      .i_b      (step),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   // State register
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and next datapath values; abort beats load beats step
   always_comb begin
      w_state_nxt   = r_state;
      w_remain_nxt  = r_remain;
      w_overrun_nxt = r_overrun;
      if (abort) begin
         w_state_nxt  = ST_IDLE;
         w_remain_nxt = CNT_ZERO;
      end else if (load) begin
         w_overrun_nxt = 1'b0;
         if (load_cnt != CNT_ZERO) begin
            w_state_nxt  = ST_RUN;
            w_remain_nxt = load_cnt;
         end else begin
            w_state_nxt  = ST_DONE;
            w_remain_nxt = CNT_ZERO;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
               if (step_valid && w_borrow) begin
                  w_state_nxt   = ST_DONE;
                  w_remain_nxt  = CNT_ZERO;
                  w_overrun_nxt = 1'b1;
               end else if (step_valid && (w_diff == CNT_ZERO)) begin
                  w_state_nxt  = ST_DONE;
                  w_remain_nxt = CNT_ZERO;
               end else if (step_valid) begin
                  w_remain_nxt = w_diff;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_remain_nxt = CNT_ZERO;
            end
         endcase
      end
      w_last_nxt = (w_state_nxt == ST_RUN) && (w_remain_nxt != CNT_ZERO) &&
                   (w_remain_nxt <= STEP_MAX);
   end

   // Datapath registers
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_remain  <= CNT_ZERO;
         r_last    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_remain  <= w_remain_nxt;
         r_last    <= w_last_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   // State-decoded handshake and status outputs
   always_comb begin
      step_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         ST_RUN: begin
            step_ready = 1'b1;
            busy       = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign remain  = r_remain;
   assign last    = r_last;
   assign overrun = r_overrun;

endmodule
